// File: rtl/shot_seq_ctrl.sv
// Run controller for the DSP shot engine: clear buffers, fire start, watch for completion or stall.
// Optional run-length counter enabled by defining SHOT_SEQ_PERF_EN.
module shot_seq_ctrl #(
  parameter int NSHOT_WIDTH  = 32,
  parameter int TOUT_WIDTH   = 27,
  parameter int CLR_CYCLES   = 4,
  parameter int GUARD_CYCLES = 4,
  parameter int DRAIN_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_start,
  input  logic                   cmd_abort,
  input  logic [NSHOT_WIDTH-1:0] cfg_nshot,
  input  logic [TOUT_WIDTH-1:0]  cfg_timeout,
  output logic                   stb_start,
  output logic [NSHOT_WIDTH-1:0] nshot,
  output logic                   resetacc,
  output logic                   stb_reset_bram_read,
  input  logic                   lastshotdone,
  input  logic [NSHOT_WIDTH-1:0] shotcnt,
  output logic                   busy,
  output logic                   done,
  output logic                   timeout_err,
  output logic                   aborted,
  output logic [NSHOT_WIDTH-1:0] shots_done,
  output logic [31:0]            run_cycles
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ARM   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]             r_state;
  logic [7:0]             r_cnt;
  logic                   r_lsd_prev;
  logic [NSHOT_WIDTH-1:0] r_shotcnt_prev;
  logic [TOUT_WIDTH-1:0]  r_wd;
  logic [TOUT_WIDTH-1:0]  r_tout;
  logic [NSHOT_WIDTH-1:0] r_nshot;
  logic [NSHOT_WIDTH-1:0] r_shots_done;
  logic                   r_stb_start;
  logic                   r_clr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_tout_err;
  logic                   r_aborted;

  logic                   w_active;
  logic                   w_guard_done;
  logic                   w_edge;
  logic                   w_shot_chg;
  logic [TOUT_WIDTH-1:0]  w_wd_inc;
  logic                   w_wd_fire;

  assign w_active     = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_guard_done = (r_cnt == 8'(GUARD_CYCLES));
  // r_lsd_prev is held at 0 through the guard, so a level already high at expiry reads as an edge
  assign w_edge       = w_guard_done && lastshotdone && !r_lsd_prev;
  assign w_shot_chg   = (shotcnt != r_shotcnt_prev);
  assign w_wd_inc     = (&r_wd) ? r_wd : r_wd + 1'b1;
  assign w_wd_fire    = (r_tout != '0) && !w_shot_chg && (w_wd_inc == r_tout);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_lsd_prev     <= 1'b0;
      r_shotcnt_prev <= '0;
      r_wd           <= '0;
      r_tout         <= '0;
      r_nshot        <= '0;
      r_shots_done   <= '0;
      r_stb_start    <= 1'b0;
      r_clr          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_tout_err     <= 1'b0;
      r_aborted      <= 1'b0;
    end else begin
      r_stb_start <= 1'b0;
      if (r_state == S_RUN) r_shots_done <= shotcnt + 1'b1;
      if (w_active && cmd_abort) begin
        r_aborted <= 1'b1;
        r_done    <= 1'b1;
        r_busy    <= 1'b0;
        r_clr     <= 1'b0;
        r_state   <= S_DONE;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (cmd_start) begin
              r_tout_err   <= 1'b0;
              r_aborted    <= 1'b0;
              r_shots_done <= '0;
              r_nshot      <= cfg_nshot;
              r_tout       <= cfg_timeout;
              r_cnt        <= '0;
              if (cfg_nshot == '0) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_DONE;
              end else begin
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
                r_clr   <= 1'b1;
                r_state <= S_CLEAR;
              end
            end
          end
          S_CLEAR: begin
            if (r_cnt == 8'(CLR_CYCLES - 1)) begin
              r_clr       <= 1'b0;
              r_stb_start <= 1'b1;
              r_cnt       <= '0;
              r_state     <= S_ARM;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          S_ARM: begin
            r_cnt          <= '0;
            r_wd           <= '0;
            r_lsd_prev     <= 1'b0;
            r_shotcnt_prev <= shotcnt;
            r_state        <= S_RUN;
          end
          S_RUN: begin
            r_shotcnt_prev <= shotcnt;
            r_wd           <= w_shot_chg ? '0 : w_wd_inc;
            if (!w_guard_done) begin
              r_cnt      <= r_cnt + 8'd1;
              r_lsd_prev <= 1'b0;
            end else begin
              r_lsd_prev <= lastshotdone;
            end
            // completion beats a watchdog expiry in the same cycle
            if (w_edge) begin
              r_cnt   <= '0;
              r_state <= S_DRAIN;
            end else if (w_wd_fire) begin
              r_tout_err <= 1'b1;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_state    <= S_DONE;
            end
          end
          S_DRAIN: begin
            if (r_cnt == 8'(DRAIN_CYCLES - 1)) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SHOT_SEQ_PERF_EN
  logic [31:0] r_run_cycles;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_cycles <= '0;
    end else if (!w_active && cmd_start) begin
      r_run_cycles <= '0;
    end else if (w_active && (r_run_cycles != 32'hFFFF_FFFF)) begin
      r_run_cycles <= r_run_cycles + 32'd1;
    end
  end
  assign run_cycles = r_run_cycles;
`else
  assign run_cycles = '0;
`endif

  assign stb_start           = r_stb_start;
  assign nshot               = r_nshot;
  assign resetacc            = r_clr;
  assign stb_reset_bram_read = r_clr;
  assign busy                = r_busy;
  assign done                = r_done;
  assign timeout_err         = r_tout_err;
  assign aborted             = r_aborted;
  assign shots_done          = r_shots_done;

endmodule

// File: tb/tb_shot_seq_ctrl.sv
// Directed bench for shot_seq_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_shot_seq_ctrl;

`ifdef SHOT_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start;
  logic        cmd_abort;
  logic [31:0] cfg_nshot;
  logic [26:0] cfg_timeout;
  logic        stb_start;
  logic [31:0] nshot;
  logic        resetacc;
  logic        stb_reset_bram_read;
  logic        lastshotdone;
  logic [31:0] shotcnt;
  logic        busy;
  logic        done;
  logic        timeout_err;
  logic        aborted;
  logic [31:0] shots_done;
  logic [31:0] run_cycles;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  shot_seq_ctrl dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .cfg_nshot(cfg_nshot), .cfg_timeout(cfg_timeout), .stb_start(stb_start),
    .nshot(nshot), .resetacc(resetacc), .stb_reset_bram_read(stb_reset_bram_read),
    .lastshotdone(lastshotdone), .shotcnt(shotcnt), .busy(busy), .done(done),
    .timeout_err(timeout_err), .aborted(aborted), .shots_done(shots_done),
    .run_cycles(run_cycles)
  );

  typedef struct {
    logic        start, abort;
    logic [31:0] ncfg;
    logic        lsd;
    logic [31:0] sc;
    logic        e_stb, e_clr, e_busy, e_done, e_abt;
    logic [31:0] e_nshot, e_shots;
  } vec_t;

  vec_t tv [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sv(input int i, input int st, input int ab, input int nc, input int l, input int s,
                    input int es, input int ec, input int eb, input int ed, input int ea,
                    input int en, input int esh);
    tv[i].start = st[0]; tv[i].abort = ab[0]; tv[i].ncfg = nc; tv[i].lsd = l[0]; tv[i].sc = s;
    tv[i].e_stb = es[0]; tv[i].e_clr = ec[0]; tv[i].e_busy = eb[0]; tv[i].e_done = ed[0];
    tv[i].e_abt = ea[0]; tv[i].e_nshot = en; tv[i].e_shots = esh;
  endtask

  task automatic do_start(input int n, input int to);
    cfg_nshot   = n;
    cfg_timeout = 27'(to);
    cmd_start   = 1'b1;
    step();
    cmd_start   = 1'b0;
  endtask

  // Engine model: events keyed to cycles after the observed stb_start (-1 = unused)
  task automatic run_engine(input int sc1_k, input int sc2_k, input int lsd_lo_k, input int lsd_hi_k,
                            output int t_stb, output int t_done, output int n_stb,
                            output int n_clr, output int n_bram, output int n_busy);
    int k;
    t_stb = -1; t_done = -1; n_stb = 0; n_clr = 0; n_bram = 0; n_busy = 0;
    for (int c = 0; c < 400; c++) begin
      if (resetacc) n_clr++;
      if (stb_reset_bram_read) n_bram++;
      if (busy) n_busy++;
      if (stb_start) begin
        n_stb++;
        if (t_stb < 0) t_stb = c;
      end
      if (done) begin
        t_done = c;
        break;
      end
      if (t_stb >= 0) begin
        k = c - t_stb;
        if (k == sc1_k) shotcnt = 1;
        if (k == sc2_k) shotcnt = 2;
        if (k == lsd_lo_k) lastshotdone = 1'b0;
        if (k == lsd_hi_k) lastshotdone = 1'b1;
      end
      step();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int t_stb, t_done, n_stb, n_clr, n_bram, n_busy;

    sv( 0, 1,0,0, 0,0,  0,0,0,1,0, 0,0);
    sv( 1, 0,0,0, 0,0,  0,0,0,1,0, 0,0);
    sv( 2, 1,0,7, 0,0,  0,1,1,0,0, 7,0);
    sv( 3, 1,0,9, 0,0,  0,1,1,0,0, 7,0);
    sv( 4, 0,0,0, 0,0,  0,1,1,0,0, 7,0);
    sv( 5, 0,0,0, 0,0,  0,1,1,0,0, 7,0);
    sv( 6, 0,0,0, 0,0,  1,0,1,0,0, 7,0);
    sv( 7, 0,0,0, 1,6,  0,0,1,0,0, 7,0);
    sv( 8, 0,0,0, 1,6,  0,0,1,0,0, 7,7);
    sv( 9, 0,0,0, 1,6,  0,0,1,0,0, 7,7);
    sv(10, 0,0,0, 1,7,  0,0,1,0,0, 7,8);
    sv(11, 0,0,0, 1,7,  0,0,1,0,0, 7,8);
    sv(12, 0,1,0, 1,7,  0,0,0,1,1, 7,8);
    sv(13, 1,1,0, 0,0,  0,0,0,1,0, 0,0);
    sv(14, 0,1,0, 0,0,  0,0,0,1,0, 0,0);

    reset = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; cfg_nshot = 0; cfg_timeout = '0;
    lastshotdone = 1'b0; shotcnt = 0;
    #12;
    chk("rst_stb_start", 32'(stb_start), 0);
    chk("rst_resetacc", 32'(resetacc), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_nshot", nshot, 0);
    chk("rst_run_cycles", run_cycles, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    for (int i = 0; i < 15; i++) begin
      cmd_start = tv[i].start; cmd_abort = tv[i].abort; cfg_nshot = tv[i].ncfg;
      lastshotdone = tv[i].lsd; shotcnt = tv[i].sc;
      step();
      chk($sformatf("v%0d_stb_start", i), 32'(stb_start), 32'(tv[i].e_stb));
      chk($sformatf("v%0d_resetacc", i), 32'(resetacc), 32'(tv[i].e_clr));
      chk($sformatf("v%0d_bram_rst", i), 32'(stb_reset_bram_read), 32'(tv[i].e_clr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].e_busy));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].e_done));
      chk($sformatf("v%0d_aborted", i), 32'(aborted), 32'(tv[i].e_abt));
      chk($sformatf("v%0d_nshot", i), nshot, tv[i].e_nshot);
      chk($sformatf("v%0d_shots_done", i), shots_done, tv[i].e_shots);
    end
    cmd_start = 1'b0; cmd_abort = 1'b0; lastshotdone = 1'b0; shotcnt = 0;
    step();

    // Normal run: nshot=3, lastshotdone 50 cycles after stb_start
    do_start(3, 0);
    run_engine(10, 30, -1, 50, t_stb, t_done, n_stb, n_clr, n_bram, n_busy);
    chk("A_stb_latency", t_stb, 4);
    chk("A_stb_count", n_stb, 1);
    chk("A_resetacc_cycles", n_clr, 4);
    chk("A_bram_rst_cycles", n_bram, 4);
    chk("A_done_after_stb", t_done - t_stb, 67);
    chk("A_busy_cycles", n_busy, 71);
    chk("A_nshot", nshot, 3);
    chk("A_shots_done", shots_done, 3);
    chk("A_busy_end", 32'(busy), 0);
    chk("A_timeout_err", 32'(timeout_err), 0);
    chk("A_run_cycles", run_cycles, PERF ? 71 : 0);

    // Stale lastshotdone (still high from A) during guard, real edge at k=30
    do_start(2, 0);
    chk("B_done_cleared", 32'(done), 0);
    chk("B_shots_cleared", shots_done, 0);
    run_engine(-1, -1, 2, 30, t_stb, t_done, n_stb, n_clr, n_bram, n_busy);
    chk("B_stb_count", n_stb, 1);
    chk("B_done_after_stb", t_done - t_stb, 47);
    chk("B_shots_done", shots_done, 3);
    chk("B_nshot", nshot, 2);

    // Abort one cycle into CLEAR, with a competing start
    lastshotdone = 1'b0;
    do_start(4, 0);
    chk("C_resetacc_clear", 32'(resetacc), 1);
    cmd_abort = 1'b1; cmd_start = 1'b1; cfg_nshot = 8;
    step();
    cmd_abort = 1'b0; cmd_start = 1'b0;
    n_stb = 0;
    for (int c = 0; c < 10; c++) begin
      if (stb_start) n_stb++;
      step();
    end
    chk("C_stb_count", n_stb, 0);
    chk("C_aborted", 32'(aborted), 1);
    chk("C_done", 32'(done), 1);
    chk("C_busy", 32'(busy), 0);
    chk("C_resetacc", 32'(resetacc), 0);
    chk("C_nshot", nshot, 4);

    // Watchdog: shotcnt frozen at 2, timeout 100
    shotcnt = 0;
    do_start(5, 100);
    run_engine(5, 15, -1, -1, t_stb, t_done, n_stb, n_clr, n_bram, n_busy);
    chk("D_timeout_after_stb", t_done - t_stb, 116);
    chk("D_timeout_err", 32'(timeout_err), 1);
    chk("D_done", 32'(done), 1);
    chk("D_aborted", 32'(aborted), 0);
    chk("D_shots_done", shots_done, 3);
    chk("D_busy_cycles", n_busy, 120);
    chk("D_run_cycles", run_cycles, PERF ? 120 : 0);

    // Async reset mid-RUN
    shotcnt = 0;
    do_start(3, 0);
    for (int c = 0; c < 12; c++) step();
    chk("E_pre_busy", 32'(busy), 1);
    #3;
    reset = 1'b1;
    #1;
    chk("E_rst_stb_start", 32'(stb_start), 0);
    chk("E_rst_resetacc", 32'(resetacc), 0);
    chk("E_rst_bram_rst", 32'(stb_reset_bram_read), 0);
    chk("E_rst_busy", 32'(busy), 0);
    chk("E_rst_nshot", nshot, 0);
    chk("E_rst_shots_done", shots_done, 0);
    chk("E_rst_run_cycles", run_cycles, 0);
    @(negedge clk);
    reset = 1'b0;
    step();
    do_start(1, 0);
    run_engine(-1, -1, -1, 20, t_stb, t_done, n_stb, n_clr, n_bram, n_busy);
    chk("E_done_after_stb", t_done - t_stb, 37);
    chk("E_done", 32'(done), 1);
    chk("E_nshot", nshot, 1);
    chk("E_shots_done", shots_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
